// File: rtl/dcache_miss_sequencer.sv
// rtl/dcache_miss_sequencer.sv - round-robin miss/refill sequencer for the data cache
// Arbitrates read/write-port misses, writes back a dirty victim, then refills the block.
module dcache_miss_sequencer #(
  parameter int WORD_SIZE   = 32,
  parameter int BLOCK_SIZE  = 4,
  parameter int BLOCK_INDEX = 2,
  parameter int N_REQ       = 4,
  parameter int MEM_LATENCY = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_REQ-1:0]                req_i,
  input  logic [N_REQ*WORD_SIZE-1:0]      req_addr_i,
  input  logic                            victim_dirty_i,
  input  logic [WORD_SIZE-1:0]            victim_addr_i,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] victim_block_i,
  input  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_rblock_i,
  output logic [N_REQ-1:0]                grant_o,
  output logic [WORD_SIZE-1:0]            grant_addr_o,
  output logic                            mem_we_o,
  output logic [WORD_SIZE-1:0]            mem_addr_o,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_wblock_o,
  output logic                            fill_valid_o,
  output logic [WORD_SIZE*BLOCK_SIZE-1:0] fill_block_o,
  output logic                            busy_o
);

  localparam int CW = $clog2(MEM_LATENCY + 1);
  localparam int PW = $clog2(N_REQ);
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~(WORD_SIZE'((1 << BLOCK_INDEX) - 1));

  typedef enum logic [2:0] {IDLE, CHECK, WB, RF, RESP} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q;
  logic [PW-1:0]                   ptr_q;
  logic [N_REQ-1:0]                grant_q;
  logic [WORD_SIZE-1:0]            grant_addr_q;
  logic [WORD_SIZE-1:0]            mem_addr_q;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] mem_wblock_q;
  logic [WORD_SIZE*BLOCK_SIZE-1:0] fill_block_q;

  logic                            cnt_last;
  logic [PW-1:0]                   win_idx;
  logic [WORD_SIZE-1:0]            win_addr;

  assign cnt_last = (cnt_q == CW'(MEM_LATENCY - 1));

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    logic found;
    found   = 1'b0;
    win_idx = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req_i[(int'(ptr_q) + k) % N_REQ]) begin
        found   = 1'b1;
        win_idx = PW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == PW'(i)) win_addr = req_addr_i[i*WORD_SIZE +: WORD_SIZE];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req_i) state_d = CHECK;
      CHECK:   state_d = victim_dirty_i ? WB : RF;
      WB:      if (cnt_last) state_d = RF;
      RF:      if (cnt_last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_we_o     = 1'b0;
    fill_valid_o = 1'b0;
    busy_o       = 1'b1;
    case (state_q)
      IDLE:    busy_o       = 1'b0;
      WB:      mem_we_o     = (cnt_q == '0);
      RESP:    fill_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q        <= '0;
      ptr_q        <= PW'(N_REQ - 1);
      grant_q      <= '0;
      grant_addr_q <= '0;
      mem_addr_q   <= '0;
      mem_wblock_q <= '0;
      fill_block_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (|req_i) begin
          grant_q      <= {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          grant_addr_q <= win_addr;
          ptr_q        <= win_idx;
        end
        CHECK: begin
          if (victim_dirty_i) begin
            mem_addr_q   <= victim_addr_i & ALIGN_MASK;
            mem_wblock_q <= victim_block_i;
          end else begin
            mem_addr_q   <= grant_addr_q & ALIGN_MASK;
          end
        end
        WB: begin
          if (cnt_last) begin
            cnt_q      <= '0;
            mem_addr_q <= grant_addr_q & ALIGN_MASK;
          end else begin
            cnt_q      <= cnt_q + CW'(1);
          end
        end
        RF: begin
          if (cnt_last) begin
            cnt_q        <= '0;
            fill_block_q <= mem_rblock_i;
          end else begin
            cnt_q        <= cnt_q + CW'(1);
          end
        end
        RESP: grant_q <= '0;
        default: ;
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign grant_addr_o = grant_addr_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wblock_o = mem_wblock_q;
  assign fill_block_o = fill_block_q;

endmodule
